// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if
// Bundles the FND controller's data/control inputs and display outputs.
//   i_en        display enable (0 blanks outputs; scanning continues)
//   i_load      one-cycle strobe capturing i_value / i_dp
//   i_value     packed nibbles, nibble k = digit k, digit 0 rightmost
//   i_dp        per-digit decimal point request, 1 = lit
//   o_digit     active-low one-hot digit select
//   o_font      active-low segments {dp,g,f,e,d,c,b,a}
//   o_scan_tick one-cycle pulse in the cycle the digit index advances
// master: the side that supplies data (datapath / bench); slave: the controller.
// NUM_DIGITS must match the controller's NUM_DIGITS.
interface fnd_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    i_en;
  logic                    i_load;
  logic [4*NUM_DIGITS-1:0] i_value;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   o_digit;
  logic [7:0]              o_font;
  logic                    o_scan_tick;

  modport master (
    output i_en, i_load, i_value, i_dp,
    input  o_digit, o_font, o_scan_tick
  );

  modport slave (
    input  i_en, i_load, i_value, i_dp,
    output o_digit, o_font, o_scan_tick
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed 7-segment display controller for NUM_DIGITS digits.
// Captures a packed hex/BCD word plus decimal points into shadow registers
// on i_load and scans one digit per CLK_DIV-clock slot, driving registered
// active-low digit selects and segment font.
// Ports:
//   clk   system clock, rising edge
//   reset asynchronous active-high reset
//   bus   fnd_scan_controller_if.slave (i_en, i_load, i_value, i_dp in;
//         o_digit, o_font, o_scan_tick out)
// Parameters: NUM_DIGITS (2..8), CLK_DIV (>= 2, clocks per digit slot).
// Optional feature: define FND_LEADING_ZERO_BLANK_EN for leading-zero
// suppression (digit 0 always lit; a zero digit with dp set stays lit).
module fnd_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000
) (
  input logic                clk,
  input logic                reset,
  fnd_scan_controller_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(CLK_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]           pre;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] val_q;
  logic [NUM_DIGITS-1:0]      dp_q;

  logic [NUM_DIGITS-1:0]      blank;
  logic [NUM_DIGITS-1:0]      digit_nx;
  logic [7:0]                 font_nx;

  logic [NUM_DIGITS-1:0]      digit_q;
  logic [7:0]                 font_q;
  logic                       tick_q;

  function automatic logic [7:0] font_of(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0:    f = 8'hC0;
      4'h1:    f = 8'hF9;
      4'h2:    f = 8'hA4;
      4'h3:    f = 8'hB0;
      4'h4:    f = 8'h99;
      4'h5:    f = 8'h92;
      4'h6:    f = 8'h82;
      4'h7:    f = 8'hF8;
      4'h8:    f = 8'h80;
      4'h9:    f = 8'h90;
      4'hA:    f = 8'h88;
      4'hB:    f = 8'h83;
      4'hC:    f = 8'hC6;
      4'hD:    f = 8'hA1;
      4'hE:    f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blanked only
  // while every digit above it is blanked too. Digit 0 is never visited.
  always_comb begin
    logic higher;
    blank  = '0;
    higher = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      blank[k] = higher && (val_q[k] == 4'h0) && !dp_q[k];
      higher   = blank[k];
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  always_comb begin
    digit_nx = '1;
    font_nx  = 8'hFF;
    if (bus.i_en && !blank[idx]) begin
      digit_nx = ~(NUM_DIGITS'(1) << idx);
      font_nx  = font_of(val_q[idx]);
      if (dp_q[idx]) begin
        font_nx[7] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre     <= '0;
      idx     <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      digit_q <= '1;
      font_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (bus.i_load) begin
        val_q <= bus.i_value;
        dp_q  <= bus.i_dp;
      end
      // Registered tick: set one edge early so it is high while pre sits at CLK_DIV-1.
      tick_q  <= (pre == PRE_PENULT);
      digit_q <= digit_nx;
      font_q  <= font_nx;
    end
  end

  assign bus.o_digit     = digit_q;
  assign bus.o_font      = font_q;
  assign bus.o_scan_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   cyc;

  fnd_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  fnd_scan_controller #(
    .NUM_DIGITS(4),
    .CLK_DIV   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digit"}, 32'(bus.o_digit), 32'h0000000F);
    check({tag, "_font"},  32'(bus.o_font),  32'h000000FF);
    check({tag, "_tick"},  32'(bus.o_scan_tick), 32'h0);
  endtask

  // Run 16 edges; the slot shown after edge e is ((e-1)/4)%4 counted from
  // reset release. digs/fonts hold the expected value per slot, slot 0 in LSBs.
  task automatic check_frame(input string tag, input logic [15:0] digs, input logic [31:0] fonts);
    int s;
    for (int i = 0; i < 16; i++) begin
      step();
      s = ((cyc - 1) / 4) % 4;
      check($sformatf("%s_c%0d_digit", tag, cyc), 32'(bus.o_digit), 32'(digs[s*4 +: 4]));
      check($sformatf("%s_c%0d_font", tag, cyc),  32'(bus.o_font),  32'(fonts[s*8 +: 8]));
      check($sformatf("%s_c%0d_tick", tag, cyc),  32'(bus.o_scan_tick), 32'((cyc % 4) == 3));
    end
  endtask

  initial begin
    logic [15:0] d_zero;
    logic [31:0] f_zero;
    logic [15:0] d_0050;
    logic [31:0] f_0050;
    logic [15:0] d_dp0;
    logic [31:0] f_dp0;

`ifdef FND_LEADING_ZERO_BLANK_EN
    d_zero = 16'hFFFE; f_zero = 32'hFFFFFFC0;
    d_0050 = 16'hFFDE; f_0050 = 32'hFFFF92C0;
    d_dp0  = 16'hFBDE; f_dp0  = 32'hFF40C0C0;
`else
    d_zero = 16'h7BDE; f_zero = 32'hC0C0C0C0;
    d_0050 = 16'h7BDE; f_0050 = 32'hC0C092C0;
    d_dp0  = 16'h7BDE; f_dp0  = 32'hC040C0C0;
`endif

    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    reset       = 1'b0;
    bus.i_en    = 1'b1;
    bus.i_load  = 1'b0;
    bus.i_value = '0;
    bus.i_dp    = '0;

    // Reset acts without a clock edge
    #1 reset = 1'b1;
    #1 check_reset_state("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1 check_reset_state("rst_held");
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Idle scan, shadow registers at zero
    check_frame("idle", d_zero, f_zero);

    // Load 12AF / dp on digit 2; old data still shown on the load edge
    bus.i_load  = 1'b1;
    bus.i_value = 16'h12AF;
    bus.i_dp    = 4'b0100;
    step();
    bus.i_load  = 1'b0;
    bus.i_value = 16'hFFFF;
    bus.i_dp    = 4'b1111;
    check("load_edge_digit", 32'(bus.o_digit), 32'hE);
    check("load_edge_font",  32'(bus.o_font),  32'hC0);
    check_frame("v12AF", 16'h7BDE, 32'hF924888E);

    // Display disabled for 10 edges mid-scan; counters keep running
    bus.i_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("dis_c%0d_digit", cyc), 32'(bus.o_digit), 32'hF);
      check($sformatf("dis_c%0d_font", cyc),  32'(bus.o_font),  32'hFF);
      check($sformatf("dis_c%0d_tick", cyc),  32'(bus.o_scan_tick), 32'((cyc % 4) == 3));
    end
    bus.i_en = 1'b1;
    step();
    // cyc 44: slot (43/4)%4 = 2 -> digit 2 = '2' with dp
    check("reen_digit", 32'(bus.o_digit), 32'hB);
    check("reen_font",  32'(bus.o_font),  32'h24);

    // Advance into slot 2 again and reset mid-slot
    while (cyc < 57) step();
    check("pre_rst_digit", 32'(bus.o_digit), 32'hB);
    check("pre_rst_font",  32'(bus.o_font),  32'h24);
    #2 reset = 1'b1;
    #1 check_reset_state("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1 check_reset_state("rst_mid_held");
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    step();
    check("restart_digit", 32'(bus.o_digit), 32'hE);
    check("restart_font",  32'(bus.o_font),  32'hC0);
    check("restart_tick",  32'(bus.o_scan_tick), 32'h0);
    step();
    step();
    check("tick_before_load", 32'(bus.o_scan_tick), 32'h1);

    // Load in the tick cycle: idx advances and data changes on the same edge
    bus.i_load  = 1'b1;
    bus.i_value = 16'h5670;
    bus.i_dp    = 4'b0000;
    step();
    bus.i_load  = 1'b0;
    check("adv_load_old_digit", 32'(bus.o_digit), 32'hE);
    check("adv_load_old_font",  32'(bus.o_font),  32'hC0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("adv_c%0d_digit", cyc), 32'(bus.o_digit), 32'hD);
      check($sformatf("adv_c%0d_font", cyc),  32'(bus.o_font),  32'hF8);
    end
    step();
    check("adv_next_digit", 32'(bus.o_digit), 32'hB);
    check("adv_next_font",  32'(bus.o_font),  32'h82);

    // Leading-zero patterns
    bus.i_load  = 1'b1;
    bus.i_value = 16'h0050;
    bus.i_dp    = 4'b0000;
    step();
    bus.i_load  = 1'b0;
    check_frame("v0050", d_0050, f_0050);

    bus.i_load  = 1'b1;
    bus.i_value = 16'h0000;
    bus.i_dp    = 4'b0000;
    step();
    bus.i_load  = 1'b0;
    check_frame("v0000", d_zero, f_zero);

    bus.i_load  = 1'b1;
    bus.i_value = 16'h0000;
    bus.i_dp    = 4'b0100;
    step();
    bus.i_load  = 1'b0;
    check_frame("v0000dp2", d_dp0, f_dp0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

- Parametrised, time-multiplexed 7-segment (FND) display controller for NUM_DIGITS digits.
- Latches a packed hex/BCD word and per-digit decimal points, then scans one digit per slot.
- Drives active-low one-hot digit selects and an active-low segment font, both registered.
- Sits between the arithmetic datapath (adder result) and the board FND pins. Successor to the separate 2-bit digit-select decoder and BCD-to-font decoder.

## Interface
Parameters:
- NUM_DIGITS, 4 — number of digits; legal range 2..8.
- CLK_DIV, 100000 — clocks per digit slot; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_en  in  1  display enable; 0 blanks all outputs, scanning continues.
- i_load  in  1  single-cycle strobe; captures i_value and i_dp into shadow registers.
- i_value  in  4*NUM_DIGITS  packed nibbles; nibble k ([4k+3:4k]) is digit k; digit 0 is rightmost.
- i_dp  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- o_digit  out  NUM_DIGITS  digit select, active-low one-hot; all ones = none selected.
- o_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_scan_tick  out  1  one-cycle pulse when the digit index advances.

## Operation
- Prescaler `pre`: counts 0..CLK_DIV-1 and wraps to 0.
- Digit index `idx` (width clog2(NUM_DIGITS)):
  - Increments when pre == CLK_DIV-1.
  - Wraps from NUM_DIGITS-1 to 0; never holds an illegal value, including for non-power-of-2 NUM_DIGITS.
- o_scan_tick is high exactly in the cycle where pre == CLK_DIV-1.
- Shadow registers `val_q` and `dp_q`: loaded from i_value and i_dp at any edge with i_load=1; hold otherwise. The display always shows the shadow contents, never the live inputs.
- Font for nibble n (dp bit 1 = off), hex codes:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E
  - dp_q[idx]=1 clears bit 7.
- Next-output function:
  - i_en=0 or digit blanked: o_digit = all ones, o_font = 8'hFF.
  - Otherwise: o_digit = ~(1<<idx), o_font = font(val_q[idx]) with the dp applied.
- States: the (pre, idx) counter pair is the whole control state; no other FSM.

## Timing
- Reset values: pre=0, idx=0, val_q=0, dp_q=0, o_digit=all ones, o_font=8'hFF, o_scan_tick=0. Reset is effective immediately, without waiting for a clock edge.
- Output latency: 1 cycle. o_digit/o_font at edge t+1 reflect idx, val_q, dp_q and i_en as they stand after edge t.
- Load-to-display: i_load sampled at edge k; new data appears on the outputs at edge k+1, provided the current idx selects a changed digit.
- i_load concurrent with an idx advance: both take effect at the same edge; the new digit shows the new data one cycle later.
- i_en toggling: takes effect on the next edge only; pre and idx are unaffected.
- Reset asserted mid-slot: all counters and outputs return to reset values; scanning restarts at digit 0 with a full CLK_DIV slot after reset deasserts.

## Configuration
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit k ≥ 1 is blanked when val_q[k]==0, dp_q[k]==0, and every higher digit is blanked as well.
  - Digit 0 is never blanked.
  - A blanked slot still consumes its scan time and o_scan_tick.
- Undefined: no digit is ever blanked except by i_en=0.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=4.
- Reset release, i_en=1, no load → o_digit cycles E,D,B,7 with each value held 4 cycles; o_font=C0 throughout (macro undefined); o_scan_tick pulses every 4th cycle.
- Load i_value=16'h12AF, i_dp=4'b0100 → slot 0 font 8E, slot 1 88, slot 2 24 (2 with dp), slot 3 F9.
- Set i_en=0 for 10 cycles mid-scan → o_digit=F and o_font=FF from the next edge; on re-enable, scanning resumes at the idx the counters have reached.
- Assert reset during slot 2 → o_digit=F and o_font=FF immediately; after release, digit 0 is selected first.
- With FND_LEADING_ZERO_BLANK_EN defined, load 16'h0050 → slots 3 and 2 show o_digit=F, o_font=FF; slot 1 shows 92; slot 0 shows C0. Load 16'h0000 → only slot 0 is lit, showing C0.
- i_load pulsed in the same cycle as o_scan_tick → the next slot shows the new nibble at the first output update of that slot; the old value never appears in it.
